seq_detect_ctrl: RTL and testbench
==================================

Name: seq_detect_ctrl

Overview:
- Run controller for bit-serial pattern detection.
- Accepts bytes from an upstream producer over a valid/ready handshake and serialises them MSB-first into a pattern-match core (default pattern 1011, overlapping matches allowed).
- Counts matches, pulses per match, and ends the run at a programmable match limit or on abort.
- Sits between a byte-wide source and the status/interrupt logic.

Parameters:
- PAT_LEN, 4, pattern length in bits (2..8).
- PATTERN, 4'b1011, pattern to detect, MSB is the oldest bit; width PAT_LEN.
- COUNT_W, 8, width of the match counter and match_limit.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  arm a run; sampled only in IDLE.
- abort  in  1  terminate the current run; ignored in IDLE/DONE.
- match_limit  in  COUNT_W  stop after this many matches; 0 means unlimited. Sampled at start.
- byte_valid  in  1  upstream byte available.
- byte_data  in  8  upstream byte, serialised MSB-first.
- byte_ready  out  1  controller can accept a byte.
- busy  out  1  run in progress (LOAD or SHIFT).
- match_pulse  out  1  one-cycle pulse per detected pattern.
- match_count  out  COUNT_W  matches in the current or last run; saturates at all-ones.
- done  out  1  one-cycle pulse when a run ends.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset values: state IDLE; byte_ready=0, busy=0, match_pulse=0, match_count=0, done=0; history and bit counters cleared.
- Reset mid-run: abandons the run immediately, with no done pulse.
- State machine (registered state; outputs decoded from state/registers, no combinational input-to-output paths):
  - IDLE: if start=1, clear match_count, history and the valid-bit counter, and latch match_limit; go to LOAD.
  - LOAD: byte_ready=1. If byte_valid=1, capture byte_data into an 8-bit shift register, load bit_idx=7 and go to SHIFT.
  - SHIFT: each cycle consume shreg[7] into the match core and shift left.
    - After 8 bits, go to LOAD.
    - If the limit is reached, go to DONE at once; remaining bits of the byte are discarded.
  - DONE: done=1 for exactly one cycle, then IDLE. match_count holds until the next start.
- Timing: byte accepted at edge E; bits consumed at edges E+1..E+8; byte_ready reasserts the cycle after E+8. Throughput is one byte per 9 cycles.
- Match rule:
  - history_next = {history[PAT_LEN-2:0], bit}.
  - A match occurs when history_next == PATTERN and at least PAT_LEN bits have been consumed since start.
  - History persists across byte boundaries within a run.
  - On a match, match_pulse=1 and match_count increments at the same edge that consumes the bit.
- Limit: with limit L≠0, the match that makes match_count==L sends the FSM to DONE at that edge. If L is 0, the run continues until abort.
- Abort: in LOAD or SHIFT, go to DONE next edge. A bit consumed on that same edge still counts. Abort has priority over the limit and over the end-of-byte transition.
- start while busy: ignored. abort and start together in IDLE: start wins.

Decomposition:
- Package seq_detect_pkg: FSM state constants (IDLE, LOAD, SHIFT, DONE), default PATTERN/PAT_LEN, byte width constant.
- Sub-module seq_match_core: history register, valid-bit counter saturating at PAT_LEN, and compare. Inputs clk/reset/clear/bit_en/bit_in; output match.
- The controller owns the FSM, handshake, shift register and counters.

Test Plan:
1. start, limit=0, send 0xB0 at edge E → exactly one match_pulse at edge E+4; match_count=1; byte_ready high again after E+8; busy stays 1.
2. limit=0, send 0xB6 (10110110) → pulses at the 4th and 7th bits (overlap); match_count=2.
3. Cross-byte: send 0x01 then 0x60 → single match at the 3rd bit of the second byte; match_count=1.
4. limit=2, send 0xB6 → done pulses one cycle after the 7th-bit edge; 8th bit dropped; byte_ready stays 0; match_count=2; IDLE afterwards.
5. limit=0, assert abort in SHIFT mid-byte → done next edge, busy=0, count frozen. A start during the run is ignored; reset asserted mid-SHIFT clears everything with no done pulse.
6. Backpressure/reset of history: hold byte_valid=0 in LOAD for 5 cycles → no state change. A new start clears history, so 0x0B split as ...1 | 011 across runs gives no match.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared constants for the bit-serial pattern detection controller:
// FSM state encodings, default pattern and byte width.
package seq_detect_pkg;

    localparam int BYTE_W      = 8;
    localparam int DEF_PAT_LEN = 4;
    localparam int DEF_COUNT_W = 8;

    localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 4'b1011;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/seq_match_core.sv
// Serial pattern matcher: keeps the last PAT_LEN bits and flags a match on the
// bit being consumed once enough bits have been seen since the last clear.
module seq_match_core
    import seq_detect_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic bit_en,
    input  logic bit_in,
    output logic match
);

    localparam int CNT_W = $clog2(PAT_LEN + 1);

    logic [PAT_LEN-1:0] history;
    logic [PAT_LEN-1:0] history_next;
    logic [CNT_W-1:0]   vcnt;

    assign history_next = {history[PAT_LEN-2:0], bit_in};

    // vcnt counts bits before this one, so PAT_LEN-1 means this bit completes a full window
    assign match = bit_en && (history_next == PATTERN) && (vcnt >= CNT_W'(PAT_LEN - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            history <= '0;
            vcnt    <= '0;
        end else if (bit_en) begin
            history <= history_next;
            if (vcnt != CNT_W'(PAT_LEN))
                vcnt <= vcnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Run controller: accepts bytes over valid/ready, serialises them MSB-first
// into the match core, counts matches and ends the run on limit or abort.
//
// state | meaning
// IDLE  | waiting for start; match_count holds last result
// LOAD  | byte_ready high, waiting for an upstream byte
// SHIFT | feeding one shift-register bit per cycle into the match core
// DONE  | one-cycle done pulse, then back to IDLE
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int                 PAT_LEN = DEF_PAT_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
    parameter int                 COUNT_W = DEF_COUNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [COUNT_W-1:0] match_limit,
    input  logic               byte_valid,
    input  logic [BYTE_W-1:0]  byte_data,
    output logic               byte_ready,
    output logic               busy,
    output logic               match_pulse,
    output logic [COUNT_W-1:0] match_count,
    output logic               done
);

    localparam int IDX_W = $clog2(BYTE_W);

    logic [1:0]         state;
    logic [1:0]         state_next;
    logic [BYTE_W-1:0]  shreg;
    logic [IDX_W-1:0]   bit_idx;
    logic [COUNT_W-1:0] limit_q;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_inc;
    logic               match_pulse_q;
    logic               core_clear;
    logic               bit_en;
    logic               core_match;
    logic               limit_hit;
    logic               accept;

    assign core_clear = (state == ST_IDLE) && start;
    assign bit_en     = (state == ST_SHIFT);
    // abort in LOAD wins over a simultaneous byte, which is then dropped
    assign accept     = (state == ST_LOAD) && byte_valid && !abort;
    assign count_inc  = (&count_q) ? count_q : count_q + 1'b1;
    assign limit_hit  = core_match && (limit_q != '0) && (count_inc == limit_q);

    seq_match_core #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .clear  (core_clear),
        .bit_en (bit_en),
        .bit_in (shreg[BYTE_W-1]),
        .match  (core_match)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_LOAD;
            ST_LOAD: begin
                if (abort)           state_next = ST_DONE;
                else if (byte_valid) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (abort || limit_hit) state_next = ST_DONE;
                else if (bit_idx == '0) state_next = ST_LOAD;
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            shreg         <= '0;
            bit_idx       <= '0;
            limit_q       <= '0;
            count_q       <= '0;
            match_pulse_q <= 1'b0;
        end else begin
            state         <= state_next;
            match_pulse_q <= core_match;

            if (core_clear) begin
                count_q <= '0;
                limit_q <= match_limit;
            end else if (core_match) begin
                count_q <= count_inc;
            end

            if (accept) begin
                shreg   <= byte_data;
                bit_idx <= IDX_W'(BYTE_W - 1);
            end else if (bit_en) begin
                shreg   <= {shreg[BYTE_W-2:0], 1'b0};
                bit_idx <= bit_idx - 1'b1;
            end
        end
    end

    assign byte_ready  = (state == ST_LOAD);
    assign busy        = (state == ST_LOAD) || (state == ST_SHIFT);
    assign done        = (state == ST_DONE);
    assign match_pulse = match_pulse_q;
    assign match_count = count_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: per-bit pulse/ready/done masks for each
// byte are compared against hand-derived values.
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] match_limit;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_ready;
    logic       busy;
    logic       match_pulse;
    logic [7:0] match_count;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [7:0] pm, rm, dm;

    seq_detect_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .match_limit (match_limit),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .busy        (busy),
        .match_pulse (match_pulse),
        .match_count (match_count),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] lim);
        start       = 1'b1;
        match_limit = lim;
        tick();
        start       = 1'b0;
        chk("start_busy", busy, 1);
    endtask

    task automatic do_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_done", done, 1);
        chk("abort_busy", busy, 0);
        tick();
        chk("abort_done_clr", done, 0);
    endtask

    // bit k of each mask = signal value just after edge E+k+1 (E = accept edge)
    task automatic send_byte(input logic [7:0] b, input int nbits,
                             output logic [7:0] pmask, output logic [7:0] rmask,
                             output logic [7:0] dmask);
        int waited = 0;
        while (!byte_ready && waited < 20) begin
            tick();
            waited++;
        end
        chk("ready_wait", byte_ready, 1);
        byte_valid = 1'b1;
        byte_data  = b;
        tick();
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        pmask = '0;
        rmask = '0;
        dmask = '0;
        for (int k = 0; k < nbits; k++) begin
            tick();
            pmask[k] = match_pulse;
            rmask[k] = byte_ready;
            dmask[k] = done;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        abort       = 1'b0;
        match_limit = 8'd0;
        byte_valid  = 1'b0;
        byte_data   = 8'h00;
        repeat (3) tick();
        chk("rst_ready", byte_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pulse", match_pulse, 0);
        chk("rst_count", match_count, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // single match in 0xB0 at bit 4
        do_start(8'd0);
        chk("t1_ready", byte_ready, 1);
        send_byte(8'hB0, 8, pm, rm, dm);
        chk("t1_pulses", pm, 8'h08);
        chk("t1_ready_mask", rm, 8'h80);
        chk("t1_done_mask", dm, 8'h00);
        chk("t1_count", match_count, 1);
        chk("t1_busy", busy, 1);
        do_abort();
        chk("t1_count_frozen", match_count, 1);

        // overlapping matches in 0xB6 at bits 4 and 7
        do_start(8'd0);
        chk("t2_count_clr", match_count, 0);
        send_byte(8'hB6, 8, pm, rm, dm);
        chk("t2_pulses", pm, 8'h48);
        chk("t2_count", match_count, 2);
        do_abort();

        // cross-byte match: 0x01 then 0x60 matches at bit 3 of the second byte
        do_start(8'd0);
        send_byte(8'h01, 8, pm, rm, dm);
        chk("t3_pulses_a", pm, 8'h00);
        send_byte(8'h60, 8, pm, rm, dm);
        chk("t3_pulses_b", pm, 8'h04);
        chk("t3_count", match_count, 1);
        do_abort();

        // limit 2: second match at bit 7 ends the run, bit 8 dropped
        do_start(8'd2);
        send_byte(8'hB6, 7, pm, rm, dm);
        chk("t4_pulses", pm, 8'h48);
        chk("t4_done_mask", dm, 8'h40);
        chk("t4_ready_mask", rm, 8'h00);
        chk("t4_count", match_count, 2);
        chk("t4_busy", busy, 0);
        tick();
        chk("t4_done_clr", done, 0);
        chk("t4_ready_idle", byte_ready, 0);
        chk("t4_busy_idle", busy, 0);
        chk("t4_count_hold", match_count, 2);
        tick();
        chk("t4_pulse_idle", match_pulse, 0);

        // start ignored mid-run; abort on bit 7 still counts that bit's match
        do_start(8'd0);
        send_byte(8'hB6, 5, pm, rm, dm);
        chk("t5_pulses", pm, 8'h08);
        chk("t5_count_a", match_count, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_start_busy", busy, 1);
        chk("t5_start_ready", byte_ready, 0);
        chk("t5_start_count", match_count, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t5_abort_pulse", match_pulse, 1);
        chk("t5_abort_count", match_count, 2);
        chk("t5_abort_done", done, 1);
        chk("t5_abort_busy", busy, 0);
        tick();
        chk("t5_done_clr", done, 0);
        chk("t5_count_frozen", match_count, 2);

        // reset mid-SHIFT abandons the run without a done pulse
        do_start(8'd0);
        send_byte(8'hB6, 4, pm, rm, dm);
        chk("t5r_pulses", pm, 8'h08);
        reset = 1'b1;
        tick();
        chk("t5r_count", match_count, 0);
        chk("t5r_busy", busy, 0);
        chk("t5r_done", done, 0);
        chk("t5r_pulse", match_pulse, 0);
        chk("t5r_ready", byte_ready, 0);
        reset = 1'b0;
        tick();
        chk("t5r_done_after", done, 0);
        tick();
        chk("t5r_done_after2", done, 0);
        chk("t5r_busy_after", busy, 0);

        // backpressure in LOAD, then history cleared by a new start
        do_start(8'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t6_hold_ready", byte_ready, 1);
            chk("t6_hold_busy", busy, 1);
        end
        send_byte(8'h01, 8, pm, rm, dm);
        chk("t6_pulses_a", pm, 8'h00);
        do_abort();
        do_start(8'd0);
        send_byte(8'h60, 8, pm, rm, dm);
        chk("t6_pulses_b", pm, 8'h00);
        chk("t6_count", match_count, 0);
        do_abort();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
